// File: rtl/fmul_booth_csa_accum.sv
// rtl/fmul_booth_csa_accum.sv - iterative radix-4 Booth / carry-save mantissa multiplier
//
// Purpose: takes one unsigned mantissa pair and retires one radix-4 Booth digit
// per cycle into a carry-save sum/carry pair. The pair is added downstream by the
// final adder to give the exact product.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   in_valid_i   operand pair valid
//   in_ready_o   block can accept operands (IDLE, or DONE while out_ready_i)
//   op_a_i       multiplicand, unsigned, MANT_W bits
//   op_b_i       multiplier, unsigned, MANT_W bits
//   out_valid_o  sum_vec_o/carry_vec_o hold a complete result
//   out_ready_i  downstream consumes the result
//   sum_vec_o    carry-save sum vector, OUT_W bits
//   carry_vec_o  carry-save carry vector, OUT_W bits
//   busy_o       high while accumulating digits
module fmul_booth_csa_accum #(
  parameter int MANT_W = 24,
  parameter int OUT_W  = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [MANT_W-1:0] op_a_i,
  input  logic [MANT_W-1:0] op_b_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [OUT_W-1:0]  sum_vec_o,
  output logic [OUT_W-1:0]  carry_vec_o,
  output logic              busy_o
);

  localparam int N_DIG = MANT_W / 2 + 1;
  localparam int CNT_W = $clog2(N_DIG);
  // Multiplier plus an implicit 0 below the LSB and two zero bits above,
  // so the top digit sees a non-negative operand.
  localparam int B_W   = MANT_W + 3;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [OUT_W-1:0]   a_q, a_d;
  logic [B_W-1:0]     b_q, b_d;
  logic [OUT_W-1:0]   s_q, s_d;
  logic [OUT_W-1:0]   c_q, c_d;

  logic               accept;
  logic [OUT_W-1:0]   a_x2;
  logic [OUT_W-1:0]   pp;

  assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q == ACCUM);
  assign sum_vec_o   = s_q;
  assign carry_vec_o = c_q;

  // a_q is pre-shifted by 2k and b_q is shifted right by 2k as digits retire,
  // so the current digit is always b_q[2:0] and its weight is already in a_q.
  assign a_x2 = a_q << 1;

  always_comb begin
    pp = '0;
    unique case (b_q[2:0])
      3'b001, 3'b010: pp = a_q;
      3'b011:         pp = a_x2;
      3'b100:         pp = ~a_x2 + OUT_W'(1);
      3'b101, 3'b110: pp = ~a_q + OUT_W'(1);
      default:        pp = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          // In DONE this is the same-edge handoff: the old result leaves as the
          // new operands arrive.
          state_d = ACCUM;
          k_d     = '0;
          a_d     = OUT_W'(op_a_i);
          b_d     = {2'b00, op_b_i, 1'b0};
          s_d     = '0;
          c_d     = '0;
        end else if (state_q == DONE && out_ready_i) begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        s_d = s_q ^ c_q ^ pp;
        c_d = ((s_q & c_q) | (s_q & pp) | (c_q & pp)) << 1;
        a_d = a_q << 2;
        b_d = b_q >> 2;
        if (k_q == CNT_W'(N_DIG - 1)) begin
          state_d = DONE;
        end else begin
          k_d = k_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
    end
  end

endmodule

// File: tb/tb_fmul_booth_csa_accum.sv
// tb/tb_fmul_booth_csa_accum.sv - self-checking bench for fmul_booth_csa_accum
module tb_fmul_booth_csa_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] op_a;
  logic [23:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum_vec;
  logic [63:0] carry_vec;
  logic        busy;

  fmul_booth_csa_accum #(.MANT_W(24), .OUT_W(64)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .sum_vec_o  (sum_vec),
    .carry_vec_o(carry_vec),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          n_pop = 0;
  logic [63:0] exp_q[$];
  int          acc_q[$];
  bit          lat_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pushes on acceptance, checks latency on the first valid cycle,
  // pops and checks the product on handoff. Called at the falling edge.
  task automatic monitor();
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      lat_seen = 0;
      return;
    end
    if (out_valid) begin
      chk("result_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        if (!lat_seen) begin
          chk("latency", 64'(cyc - acc_q[0]), 64'd13);
          lat_seen = 1;
        end
        if (out_ready) begin
          chk("product", sum_vec + carry_vec, exp_q[0]);
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          lat_seen = 0;
          n_pop++;
        end
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(64'(op_a) * 64'(op_b));
      acc_q.push_back(cyc + 1);
    end
  endtask

  // One clock: monitor at the falling edge, then return 1 time unit after the
  // rising edge so inputs are driven away from the active edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Issue one op with out_ready high, wait for out_valid and check the
  // latency, the busy window and the literal product; the handoff follows.
  task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                        input logic [63:0] exp);
    int n;
    int nbusy;
    in_valid  = 1'b1;
    op_a      = a;
    op_b      = b;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    op_a     = 24'h5A5A5A;
    op_b     = 24'hA5A5A5;
    n        = 0;
    nbusy    = 0;
    while (!out_valid && n < 40) begin
      if (busy) nbusy++;
      step();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd13);
    chk({tag, "_busy"}, 64'(nbusy), 64'd13);
    chk({tag, "_sum"}, sum_vec + carry_vec, exp);
    step();
  endtask

  initial begin
    logic [63:0] s_snap;
    logic [63:0] c_snap;
    int          n;
    int          issued;
    int          pop_base;
    bit          acc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_sum", sum_vec, 64'd0);
    chk("rst_carry", carry_vec, 64'd0);
    rst_n = 1'b1;
    step();

    run_op("max", 24'hFFFFFF, 24'hFFFFFF, 64'h0000_FFFF_FE00_0001);
    run_op("msb", 24'h800000, 24'h800000, 64'h0000_4000_0000_0000);
    run_op("zero", 24'h000000, 24'h123456, 64'd0);

    // Backpressure with in_valid asserted while busy (must be ignored).
    in_valid  = 1'b1;
    op_a      = 24'hABCDEF;
    op_b      = 24'h123457;
    out_ready = 1'b0;
    step();
    op_a = 24'h000001;
    op_b = 24'h000001;
    for (int i = 0; i < 4; i++) begin
      chk("busy_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk("bp_lat", 64'(n + 4), 64'd13);
    chk("bp_sum", sum_vec + carry_vec, 64'hABCDEF * 64'h123457);
    s_snap = sum_vec;
    c_snap = carry_vec;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_sum_stable", sum_vec, s_snap);
      chk("bp_carry_stable", carry_vec, c_snap);
    end

    // Same-edge handoff and accept.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op_a      = 24'h000003;
    op_b      = 24'h000005;
    step();
    in_valid = 1'b0;
    chk("handoff_valid_drop", 64'(out_valid), 64'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk("handoff_lat", 64'(n), 64'd13);
    chk("handoff_sum", sum_vec + carry_vec, 64'd15);
    step();

    // Reset in the middle of accumulation.
    in_valid = 1'b1;
    op_a     = 24'h654321;
    op_b     = 24'hFEDCBA;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_sum", sum_vec, 64'd0);
    chk("midrst_carry", carry_vec, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("postrst_in_ready", 64'(in_ready), 64'd1);
    run_op("post_rst", 24'h000007, 24'h000009, 64'd63);

    // Random regression with random downstream stalls.
    pop_base = n_pop;
    issued   = 0;
    n        = 0;
    while (issued < 1000 && n < 60000) begin
      in_valid = 1'b1;
      op_a     = 24'($urandom);
      op_b     = 24'($urandom);
      if ($urandom_range(0, 3) == 0) op_a = 24'hFFFFFF;
      acc = 0;
      while (!acc && n < 60000) begin
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        acc = in_ready;
        step();
        n++;
      end
      if (acc) issued++;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() > 0 || out_valid) && n < 100) begin
      step();
      n++;
    end
    chk("rand_issued", 64'(issued), 64'd1000);
    chk("rand_results", 64'(n_pop - pop_base), 64'd1000);
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
